fv_stim_replay: RTL and testbench
=================================

# fv_stim_replay

Parametrised, synthesizable stimulus replay engine for the oc8051 formal/simulation top. It holds a table of DEPTH input vectors of WIDTH bits, each with a repeat count, and replays them to the DUT primary inputs, one vector per cycle. It supports one-shot, hold-last and loop modes. It also monitors the DUT `assert_valid` output and records the first failing cycle, which replaces the hand-written per-bit stimulus sequence.

## Interface
- `WIDTH`, 81, vector width (wbd_dat 8 + wbi_dat 32 + 4 Wishbone ack/err + 4 ports × 8 + 5 timer/serial inputs).
- `DEPTH`, 16, number of table entries; power of two, ≥2.
- `RPT_W`, 8, repeat-count width.
- `CYC_W`, 16, cycle-counter width.
- `clk  in  1  clock; all state changes on rising edge.`
- `rst  in  1  reset, asynchronous, active-high.`
- `cfg_we  in  1  table write strobe.`
- `cfg_addr  in  log2(DEPTH)  table write index.`
- `cfg_vec  in  WIDTH  vector to store.`
- `cfg_rpt  in  RPT_W  extra cycles to hold the vector (0 = 1 cycle).`
- `len  in  log2(DEPTH)+1  entries to replay (0..DEPTH), sampled at start.`
- `mode  in  2  0 ONESHOT, 1 HOLD, 2 LOOP, 3 reserved (treated as ONESHOT); sampled at start.`
- `start  in  1  begin replay pulse.`
- `chk_i  in  1  DUT assert_valid.`
- `stim_o  out  WIDTH  vector driven to DUT inputs.`
- `stim_valid_o  out  1  stim_o is a table vector this cycle.`
- `busy_o  out  1  replay in progress (PLAY or HOLD).`
- `done_o  out  1  one-cycle pulse on end of ONESHOT/HOLD sequence.`
- `fail_o  out  1  sticky: chk_i seen low while stim_valid_o high.`
- `fail_cyc_o  out  CYC_W  cycle index of first failure.`

## Operation
- States: IDLE, PLAY, HOLD.
- Reset behaviour: state IDLE; table entries (vectors and repeat counts) cleared to 0; all outputs 0, including stim_o, fail_cyc_o and fail_o.
- IDLE, start=1, len≠0: latch len and mode; set index 0, repeat counter = rpt[0], cycle counter 0; go to PLAY.
- IDLE, start=1, len=0: stay in IDLE; assert done_o for one cycle.
- PLAY: stim_o = vec[idx], stim_valid_o=1.
  - If repeat counter ≠0: decrement it.
  - Otherwise, if idx<len−1: increment idx and load rpt[idx+1].
  - Otherwise (last entry finished):
    - ONESHOT: go to IDLE; stim_o returns to 0; pulse done_o.
    - HOLD: go to HOLD; stim_o keeps the last vector; pulse done_o.
    - LOOP: idx=0, reload rpt[0]; stay in PLAY; no done_o.
- HOLD: stim_o frozen, stim_valid_o=1, busy_o=1. start=1 restarts the replay as from IDLE.
- start in PLAY is ignored. The only exit from LOOP is reset.
- cfg_we in IDLE or HOLD writes the entry. cfg_we in PLAY is ignored, so the table is stable while replaying.
- Cycle counter:
  - Increments each cycle stim_valid_o=1.
  - Saturates at all-ones.
  - Cleared at each accepted start.
- Failure capture: in any cycle with stim_valid_o=1 and chk_i=0 while fail_o=0, set fail_o and load fail_cyc_o with the current cycle count. fail_o and fail_cyc_o are cleared only by reset.

## Timing
- start sampled at edge t: stim_o = vec[0] with stim_valid_o=1 from edge t+1.
- Entry k is held for exactly rpt[k]+1 cycles. Total ONESHOT replay is Σ(rpt[k]+1) cycles over the first len entries.
- done_o is asserted in the cycle after the last replay cycle, coincident with stim_valid_o dropping (ONESHOT) or the HOLD entry (HOLD).
- chk_i is compared in the same cycle as the stim_o it responds to. The DUT path from stim_o to assert_valid is combinational or has a fixed latency that the bench accounts for.
- A write to cfg_addr at edge t is visible to a start sampled at edge t+1.
- Reset asserted mid-replay: outputs go to 0 immediately (asynchronously) and the table is cleared.

## Structure
- Shared package fv_stim_pkg:
  - state enum (IDLE/PLAY/HOLD);
  - mode encodings;
  - field offset constants for the WIDTH=81 packing, LSB first: wbd_dat, wbi_dat, wbd_err, wbd_ack, wbi_err, wbi_ack, p0..p3, rxd, t0, t1, t2, t2ex.
- One natural sub-module: fv_stim_table, a DEPTH×(WIDTH+RPT_W) register file with async-cleared flops, one write port and one combinational read port.
- The FSM, counters and failure monitor stay in the top level.

## Test plan
- Basic ONESHOT replay:
  - Stimulus: write 4 entries, vec = 0x…01, 02, 03, 04, rpt=0; len=4, mode=0, start.
  - Required: stim_o shows 01, 02, 03, 04 on cycles 1–4. done_o pulses on cycle 5; stim_o=0 and busy_o=0.
- Repeat counts:
  - Stimulus: entry0 rpt=2, entry1 rpt=0; len=2.
  - Required: vec0 held 3 cycles, vec1 for 1 cycle, done_o on cycle 5.
- HOLD mode then restart:
  - Stimulus: mode=1, len=2; after done_o, the bench holds; then rewrite entry0 and start.
  - Required: last vector held indefinitely. The new vec0 appears 1 cycle after start.
- LOOP mode with write and start during PLAY:
  - Stimulus: mode=2, len=3, rpt=0. While in PLAY, issue cfg_we and start.
  - Required: sequence 0,1,2,0,1,2… with no done_o. The write and the start have no effect.
- Failure capture:
  - Stimulus: drive chk_i=0 on replay cycles 6 and 9.
  - Required: fail_o rises at cycle 6 with fail_cyc_o=5 (0-based) and stays unchanged afterwards. A fresh start does not clear it.
- Edge cases:
  - len=0 start → done_o next cycle, stim_valid_o never 1.
  - rst asserted during PLAY → all outputs 0 immediately.
  - After reset release, start with len=1 → stim_o=0 (the cleared table).

Source files
------------

// File: rtl/fv_stim_replay_pkg.sv
// Shared types and constants for the stimulus replay engine and its register file.
// Field offsets describe how the oc8051 primary inputs are packed into one 81-bit vector.
package fv_stim_pkg;

    localparam int STIM_WIDTH = 81;
    localparam int STIM_DEPTH = 16;
    localparam int STIM_RPT_W = 8;
    localparam int STIM_CYC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_HOLD    = 2'd1;
    localparam logic [1:0] MODE_LOOP    = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    // LSB-first packing of the DUT primary inputs
    localparam int OFF_WBD_DAT = 0;
    localparam int OFF_WBI_DAT = 8;
    localparam int OFF_WBD_ERR = 40;
    localparam int OFF_WBD_ACK = 41;
    localparam int OFF_WBI_ERR = 42;
    localparam int OFF_WBI_ACK = 43;
    localparam int OFF_P0      = 44;
    localparam int OFF_P1      = 52;
    localparam int OFF_P2      = 60;
    localparam int OFF_P3      = 68;
    localparam int OFF_RXD     = 76;
    localparam int OFF_T0      = 77;
    localparam int OFF_T1      = 78;
    localparam int OFF_T2      = 79;
    localparam int OFF_T2EX    = 80;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_ONESHOT : m;
    endfunction

endpackage

// File: rtl/fv_stim_replay_if.sv
// Configuration, control and stimulus bundle between the replay engine and its user.
// The slave side is the replay engine; the master side is the harness driving it.
interface fv_stim_replay_if
    import fv_stim_pkg::*;
#(
    parameter int WIDTH = STIM_WIDTH,
    parameter int DEPTH = STIM_DEPTH,
    parameter int RPT_W = STIM_RPT_W,
    parameter int CYC_W = STIM_CYC_W
);
    localparam int AW = $clog2(DEPTH);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_vec;
    logic [RPT_W-1:0] cfg_rpt;
    logic [AW:0]      len;
    logic [1:0]       mode;
    logic             start;
    logic             chk_i;
    logic [WIDTH-1:0] stim_o;
    logic             stim_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             fail_o;
    logic [CYC_W-1:0] fail_cyc_o;

    modport master (
        output cfg_we, cfg_addr, cfg_vec, cfg_rpt, len, mode, start, chk_i,
        input  stim_o, stim_valid_o, busy_o, done_o, fail_o, fail_cyc_o
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_vec, cfg_rpt, len, mode, start, chk_i,
        output stim_o, stim_valid_o, busy_o, done_o, fail_o, fail_cyc_o
    );

endinterface

// File: rtl/fv_stim_replay_table.sv
// DEPTH-entry table of stimulus vectors with per-entry repeat counts.
// One synchronous write port, one combinational read port, cleared by reset.
module fv_stim_table #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 16,
    parameter int RPT_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wvec,
    input  logic [RPT_W-1:0] wrpt,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rvec,
    output logic [RPT_W-1:0] rrpt
);

    logic [WIDTH-1:0] vec_q [DEPTH];
    logic [WIDTH-1:0] vec_d [DEPTH];
    logic [RPT_W-1:0] rpt_q [DEPTH];
    logic [RPT_W-1:0] rpt_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vec_d[i] = vec_q[i];
            rpt_d[i] = rpt_q[i];
            if (we && (waddr == AW'(i))) begin
                vec_d[i] = wvec;
                rpt_d[i] = wrpt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vec_q[i] <= '0;
                rpt_q[i] <= '0;
            end
        end else begin
            vec_q <= vec_d;
            rpt_q <= rpt_d;
        end
    end

    assign rvec = vec_q[raddr];
    assign rrpt = rpt_q[raddr];

endmodule

// File: rtl/fv_stim_replay.sv
// Stimulus replay engine: plays table vectors to the DUT inputs one per cycle and
// records the cycle of the first assert_valid drop seen while a vector is applied.
//
//   state | meaning
//   IDLE  | outputs parked at 0, table writable, waiting for start
//   PLAY  | stepping through entries; table write and start ignored
//   HOLD  | last vector frozen on stim_o; table writable, start restarts
module fv_stim_replay
    import fv_stim_pkg::*;
#(
    parameter int WIDTH = STIM_WIDTH,
    parameter int DEPTH = STIM_DEPTH,
    parameter int RPT_W = STIM_RPT_W,
    parameter int CYC_W = STIM_CYC_W
) (
    input  logic clk,
    input  logic rst,
    fv_stim_replay_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [AW:0]      len_q, len_d;
    logic [1:0]       mode_q, mode_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic             stim_valid_q, stim_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [CYC_W-1:0] fail_cyc_q, fail_cyc_d;

    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_vec;
    logic [RPT_W-1:0] rd_rpt;
    logic [AW:0]      idx_nxt;
    logic             last_entry;
    logic             tbl_we;

    assign idx_nxt    = {1'b0, idx_q} + (AW+1)'(1);
    assign last_entry = (idx_nxt >= len_q);
    assign tbl_we     = bus.cfg_we && (state_q != ST_PLAY);

    // The single read port serves both the next entry during PLAY and entry 0 on (re)start.
    assign rd_addr = ((state_q == ST_PLAY) && !last_entry) ? idx_nxt[AW-1:0] : '0;

    fv_stim_table #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RPT_W(RPT_W)
    ) u_table (
        .clk  (clk),
        .rst  (rst),
        .we   (tbl_we),
        .waddr(bus.cfg_addr),
        .wvec (bus.cfg_vec),
        .wrpt (bus.cfg_rpt),
        .raddr(rd_addr),
        .rvec (rd_vec),
        .rrpt (rd_rpt)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rpt_cnt_d    = rpt_cnt_q;
        len_d        = len_q;
        mode_d       = mode_q;
        cyc_d        = cyc_q;
        stim_d       = stim_q;
        stim_valid_d = stim_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = fail_q;
        fail_cyc_d   = fail_cyc_q;

        if (stim_valid_q && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        if (stim_valid_q && !bus.chk_i && !fail_q) begin
            fail_d     = 1'b1;
            fail_cyc_d = cyc_q;
        end

        case (state_q)
            ST_PLAY: begin
                if (rpt_cnt_q != '0) begin
                    rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                end else if (!last_entry) begin
                    idx_d     = idx_nxt[AW-1:0];
                    rpt_cnt_d = rd_rpt;
                    stim_d    = rd_vec;
                end else if (mode_q == MODE_HOLD) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                end else if (mode_q == MODE_LOOP) begin
                    idx_d     = '0;
                    rpt_cnt_d = rd_rpt;
                    stim_d    = rd_vec;
                end else begin
                    state_d      = ST_IDLE;
                    stim_d       = '0;
                    stim_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                end
            end
            default: begin
                if (bus.start) begin
                    cyc_d = '0;
                    if (bus.len == '0) begin
                        state_d      = ST_IDLE;
                        stim_d       = '0;
                        stim_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        state_d      = ST_PLAY;
                        len_d        = bus.len;
                        mode_d       = norm_mode(bus.mode);
                        idx_d        = '0;
                        rpt_cnt_d    = rd_rpt;
                        stim_d       = rd_vec;
                        stim_valid_d = 1'b1;
                        busy_d       = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rpt_cnt_q    <= '0;
            len_q        <= '0;
            mode_q       <= MODE_ONESHOT;
            cyc_q        <= '0;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_cyc_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rpt_cnt_q    <= rpt_cnt_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            cyc_q        <= cyc_d;
            stim_q       <= stim_d;
            stim_valid_q <= stim_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_cyc_q   <= fail_cyc_d;
        end
    end

    assign bus.stim_o       = stim_q;
    assign bus.stim_valid_o = stim_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.fail_o       = fail_q;
    assign bus.fail_cyc_o   = fail_cyc_q;

endmodule

// File: tb/tb_fv_stim_replay.sv
// Scoreboard bench for fv_stim_replay: a table model expands each replay into the
// expected per-cycle outputs, and a negedge monitor pops and compares them.
module tb_fv_stim_replay;

    localparam int WIDTH = 81;
    localparam int DEPTH = 16;
    localparam int RPT_W = 8;
    localparam int CYC_W = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [WIDTH-1:0] vec;
        logic             valid;
        logic             busy;
        logic             done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fv_stim_replay_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPT_W(RPT_W), .CYC_W(CYC_W)) bus ();

    fv_stim_replay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPT_W(RPT_W), .CYC_W(CYC_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [WIDTH-1:0] m_vec [DEPTH];
    logic [RPT_W-1:0] m_rpt [DEPTH];
    bit               m_hold;
    logic [WIDTH-1:0] m_last;
    bit               m_fail;
    int               m_fail_cyc;

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] v, input logic va, input logic b, input logic d);
        exp_t e;
        e.vec = v; e.valid = va; e.busy = b; e.done = d;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_vec();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WIDTH-1:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && (bus.stim_valid_o || bus.done_o)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output stim=%0h valid=%0b done=%0b required=no_output at %0t",
                         bus.stim_o, bus.stim_valid_o, bus.done_o, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("stim_o", bus.stim_o, mon_e.vec);
                check("stim_valid_o", WIDTH'(bus.stim_valid_o), WIDTH'(mon_e.valid));
                check("busy_o", WIDTH'(bus.busy_o), WIDTH'(mon_e.busy));
                check("done_o", WIDTH'(bus.done_o), WIDTH'(mon_e.done));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_vec[i] = '0;
            m_rpt[i] = '0;
        end
        m_hold     = 0;
        m_last     = '0;
        m_fail     = 0;
        m_fail_cyc = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim_o"}, bus.stim_o, '0);
        check({tag, "_stim_valid_o"}, WIDTH'(bus.stim_valid_o), '0);
        check({tag, "_busy_o"}, WIDTH'(bus.busy_o), '0);
        check({tag, "_done_o"}, WIDTH'(bus.done_o), '0);
        check({tag, "_fail_o"}, WIDTH'(bus.fail_o), '0);
        check({tag, "_fail_cyc_o"}, WIDTH'(bus.fail_cyc_o), '0);
    endtask

    // Only called while the engine is idle or holding, so the write always lands.
    task automatic cfg_write(input int a, input logic [WIDTH-1:0] v, input int r);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_vec  = v;
        bus.cfg_rpt  = RPT_W'(r);
        m_vec[a]     = v;
        m_rpt[a]     = RPT_W'(r);
        if (m_hold) sb_q.push_back(mk(m_last, 1'b1, 1'b1, 1'b0));
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // extra: hold cycles after done (HOLD) or total cycles observed (LOOP).
    // fa/fb: replay cycles (1-based) with chk_i low. poke: cycle with a write+start during PLAY.
    task automatic run(input int ln, input int md, input int extra, input int fa, input int fb, input int poke);
        exp_t seq[$];
        exp_t lst[$];
        int   n;
        int   cnt;
        for (int k = 0; k < ln; k++)
            for (int r = 0; r <= int'(m_rpt[k]); r++)
                seq.push_back(mk(m_vec[k], 1'b1, 1'b1, 1'b0));
        if (ln == 0) begin
            lst.push_back(mk('0, 1'b0, 1'b0, 1'b1));
        end else if (md == 2) begin
            for (int i = 0; i < extra; i++) lst.push_back(seq[i % seq.size()]);
        end else if (md == 1) begin
            lst = seq;
            lst.push_back(mk(seq[seq.size()-1].vec, 1'b1, 1'b1, 1'b1));
            for (int i = 0; i < extra; i++) lst.push_back(mk(seq[seq.size()-1].vec, 1'b1, 1'b1, 1'b0));
        end else begin
            lst = seq;
            lst.push_back(mk('0, 1'b0, 1'b0, 1'b1));
        end
        foreach (lst[i]) sb_q.push_back(lst[i]);
        n = lst.size();

        bus.len   = (AW+1)'(ln);
        bus.mode  = 2'(md);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cnt = 0;
        for (int i = 1; i <= n; i++) begin
            check("fail_o", WIDTH'(bus.fail_o), WIDTH'(m_fail));
            check("fail_cyc_o", WIDTH'(bus.fail_cyc_o), WIDTH'(CYC_W'(m_fail_cyc)));
            bus.cfg_we = 1'b0;
            bus.start  = 1'b0;
            bus.chk_i  = 1'b1;
            if (i == poke) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = '0;
                bus.cfg_vec  = rnd_vec();
                bus.cfg_rpt  = RPT_W'(5);
                bus.start    = 1'b1;
            end
            if (i == fa || i == fb) bus.chk_i = 1'b0;
            if (lst[i-1].valid && !bus.chk_i && !m_fail) begin
                m_fail     = 1;
                m_fail_cyc = cnt;
            end
            if (lst[i-1].valid) cnt++;
            if (i < n) tick();
        end
        bus.chk_i  = 1'b1;
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        m_hold = (ln != 0) && (md == 1);
        if (m_hold) m_last = seq[seq.size()-1].vec;
    endtask

    initial begin
        int ln;
        int md;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_vec  = '0;
        bus.cfg_rpt  = '0;
        bus.len      = '0;
        bus.mode     = '0;
        bus.start    = 1'b0;
        bus.chk_i    = 1'b1;
        model_clear();
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        for (int k = 0; k < 4; k++) cfg_write(k, WIDTH'(k + 1), 0);
        run(4, 0, 0, 0, 0, 0);

        cfg_write(0, rnd_vec(), 2);
        cfg_write(1, rnd_vec(), 0);
        run(2, 0, 0, 0, 0, 0);

        run(2, 1, 5, 0, 0, 0);
        cfg_write(0, rnd_vec(), 1);
        run(2, 0, 0, 0, 0, 0);

        for (int k = 0; k < 4; k++) cfg_write(k, rnd_vec(), 2);
        run(4, 0, 0, 6, 9, 0);
        run(4, 0, 0, 0, 0, 0);
        check("fail_cyc_after_restart", WIDTH'(bus.fail_cyc_o), WIDTH'(5));

        run(0, 0, 0, 0, 0, 0);

        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < int'($urandom_range(1, 4)); w++)
                cfg_write(int'($urandom_range(0, DEPTH - 1)), rnd_vec(), int'($urandom_range(0, 3)));
            ln = int'($urandom_range(1, DEPTH));
            md = int'($urandom_range(0, 2));
            if (md == 2) md = 3;
            run(ln, md, int'($urandom_range(1, 4)), 0, 0, 0);
        end

        for (int k = 0; k < 3; k++) cfg_write(k, rnd_vec(), 0);
        run(3, 2, 10, 0, 0, 4);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_play_reset");
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();

        run(1, 0, 0, 0, 0, 0);
        tick();
        tick();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
